// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC select encoding and default vectors for the fetch PC unit
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_RAS,
    SEL_REDIR,
    SEL_EXC
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating count and silent overwrite
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_dec;
  logic [CNT_W-1:0]  count;

  // ptr always points at the next free slot; the top lives one below it
  assign ptr_dec = ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign top     = empty ? '0 : mem[ptr_dec];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr_dec] <= push_addr;
    end else if (push) begin
      // full stack: the oldest entry is overwritten and count stays saturated
      mem[ptr] <= push_addr;
      ptr      <= ptr + PTR_W'(1);
      if (count != CNT_FULL) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch-stage PC register with prioritised next-PC select, RAS and EPC
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(PC_EXC_VECTOR),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              exc_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              ras_push,
  input  logic [ADDR_W-1:0] ras_push_addr,
  input  logic              ras_pop,
  output logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic [ADDR_W-1:0] epc
);

  pc_sel_e sel;
  logic    op_en;

  assign pc_plus4 = pc_current + ADDR_W'(4);

  // stack ops only on a genuine advance; flushes and stalls leave it untouched
  assign op_en = enable & ~exc_req & ~redirect_valid;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .flush     (exc_req),
    .push      (op_en & ras_push),
    .pop       (op_en & ras_pop),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_comb begin
    sel = SEL_HOLD;
    if (exc_req) begin
      sel = SEL_EXC;
    end else if (redirect_valid) begin
      sel = SEL_REDIR;
    end else if (enable && ras_pop && !ras_empty) begin
      sel = SEL_RAS;
    end else if (enable) begin
      sel = SEL_SEQ;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_current <= RESET_VECTOR;
      epc        <= '0;
    end else begin
      case (sel)
        SEL_EXC: begin
          pc_current <= EXC_VECTOR;
          epc        <= pc_current;
        end
        SEL_REDIR: pc_current <= redirect_target;
        SEL_RAS:   pc_current <= ras_top;
        SEL_SEQ:   pc_current <= pc_plus4;
        default:   pc_current <= pc_current;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed self-checking bench for pc_unit_ras
module tb_pc_unit_ras;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        exc_req;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_pop;
  logic [31:0] pc_current;
  logic [31:0] pc_plus4;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic [31:0] epc;

  int compared   = 0;
  int mismatched = 0;

  pc_unit_ras #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0040_0000),
    .EXC_VECTOR   (32'h0000_0080),
    .RAS_DEPTH    (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .exc_req         (exc_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ras_push        (ras_push),
    .ras_push_addr   (ras_push_addr),
    .ras_pop         (ras_pop),
    .pc_current      (pc_current),
    .pc_plus4        (pc_plus4),
    .ras_top         (ras_top),
    .ras_empty       (ras_empty),
    .epc             (epc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; exc_req = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
    step(); step();
    check("rst_pc", pc_current, 32'h0040_0000);
    check("rst_plus4", pc_plus4, 32'h0040_0004);
    check("rst_empty", ras_empty, 1);
    check("rst_epc", epc, 0);
    check("rst_top", ras_top, 0);

    // sequential advance
    reset = 1'b0; enable = 1'b1;
    step(); step(); step();
    check("seq3_pc", pc_current, 32'h0040_000C);

    // stall ignores pushes
    enable = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h99;
    step(); step();
    check("stall_pc", pc_current, 32'h0040_000C);
    check("stall_empty", ras_empty, 1);
    ras_push = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_1000;
    step();
    check("redir_stall_pc", pc_current, 32'h0000_1000);
    redirect_valid = 1'b0;

    // push three, pop three, pop on empty
    enable = 1'b1; ras_push = 1'b1;
    ras_push_addr = 32'h10; step();
    ras_push_addr = 32'h20; step();
    ras_push_addr = 32'h30; step();
    check("push3_pc", pc_current, 32'h0000_100C);
    check("push3_top", ras_top, 32'h30);
    ras_push = 1'b0; ras_pop = 1'b1;
    step(); check("pop1_pc", pc_current, 32'h30);
    step(); check("pop2_pc", pc_current, 32'h20);
    step(); check("pop3_pc", pc_current, 32'h10);
    check("pop3_empty", ras_empty, 1);
    step(); check("pop_empty_pc", pc_current, 32'h14);

    // overflow: five pushes into a four-deep stack
    ras_pop = 1'b0; ras_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ras_push_addr = 32'(i * 4);
      step();
    end
    check("ovf_pc", pc_current, 32'h28);
    check("ovf_top", ras_top, 32'h14);
    ras_push = 1'b0; ras_pop = 1'b1;
    step(); check("ovf_pop1", pc_current, 32'h14);
    step(); check("ovf_pop2", pc_current, 32'h10);
    step(); check("ovf_pop3", pc_current, 32'h0C);
    step(); check("ovf_pop4", pc_current, 32'h08);
    check("ovf_empty", ras_empty, 1);
    step(); check("ovf_pop5", pc_current, 32'h0C);

    // simultaneous push and pop replaces the top
    ras_pop = 1'b0; ras_push = 1'b1;
    ras_push_addr = 32'h10; step();
    ras_push_addr = 32'h20; step();
    check("pp_pre_pc", pc_current, 32'h14);
    ras_pop = 1'b1; ras_push_addr = 32'h50;
    step();
    check("pp_pc", pc_current, 32'h20);
    check("pp_top", ras_top, 32'h50);
    ras_push = 1'b0;
    step(); check("pp_pop1", pc_current, 32'h50);
    step(); check("pp_pop2", pc_current, 32'h10);
    check("pp_empty", ras_empty, 1);
    // push+pop on empty acts as push only
    ras_push = 1'b1; ras_push_addr = 32'h60;
    step();
    check("pp_empty_pc", pc_current, 32'h14);
    check("pp_empty_top", ras_top, 32'h60);
    check("pp_empty_nonempty", ras_empty, 0);

    // exception beats redirect and push, flushes stack
    ras_push = 1'b0; ras_pop = 1'b0; enable = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0000_2000;
    step();
    check("exc_pre_pc", pc_current, 32'h0000_2000);
    exc_req = 1'b1; redirect_target = 32'h0000_3000; ras_push = 1'b1;
    ras_push_addr = 32'h70; enable = 1'b1;
    step();
    check("exc_pc", pc_current, 32'h0000_0080);
    check("exc_epc", epc, 32'h0000_2000);
    check("exc_empty", ras_empty, 1);
    check("exc_top", ras_top, 0);
    exc_req = 1'b0; redirect_valid = 1'b0; ras_push = 1'b0; ras_pop = 1'b1;
    step();
    check("exc_pop_pc", pc_current, 32'h0000_0084);

    // pc_plus4 wrap
    ras_pop = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    check("wrap_pc", pc_current, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    redirect_valid = 1'b0;
    step();
    check("wrap_next_pc", pc_current, 32'h0000_0000);
    check("wrap_epc_hold", epc, 32'h0000_2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
